spi_master: RTL

- SPI mode-3 master (CPOL=1, CPHA=1), MSB first, 8-bit frames.
- Drives the MCU-link SPI slave from an on-FPGA controller, and acts as the bench driver for that slave.
- Byte-stream valid/ready interface: cs stays low across a multi-byte burst until a byte flagged last completes.
- Full-duplex: each transmitted byte returns one received byte.

---
 rtl/spi_master.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// SPI mode-3 master (CPOL=1, CPHA=1), MSB first, 8-bit frames.
// Byte-stream valid/ready front end. cs stays low across a burst until a byte
// flagged last has been shifted. Each transmitted byte returns one received byte.
module spi_master #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, NEXT, HOLD, GAP} state_t;

  // Terminal counts: each phase lasts exactly N clk cycles.
  localparam logic [7:0] DIV_END   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_END = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_END   = 8'(CS_GAP - 1);

  state_t      state, state_nxt;
  logic [7:0]  div_cnt, div_cnt_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;
  logic [7:0]  rx_shift, rx_shift_nxt;
  logic        last_byte, last_byte_nxt;
  logic        cs_nxt, sck_nxt, mosi_nxt, busy_nxt;
  logic        tx_ready_nxt, rx_valid_nxt;
  logic [7:0]  rx_data_nxt;
  logic        miso_meta, miso_sync;
  logic        handshake;

  // tx_ready is a registered function of the state, so it already implies IDLE or NEXT.
  assign handshake = tx_valid & tx_ready;

  // Two-flop synchronizer for the asynchronous miso line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // State, counters, shifters and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      div_cnt   <= 8'd0;
      bit_cnt   <= 3'd0;
      tx_shift  <= 8'd0;
      rx_shift  <= 8'd0;
      last_byte <= 1'b0;
      cs        <= 1'b1;
      sck       <= 1'b1;
      mosi      <= 1'b1;
      tx_ready  <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      tx_shift  <= tx_shift_nxt;
      rx_shift  <= rx_shift_nxt;
      last_byte <= last_byte_nxt;
      cs        <= cs_nxt;
      sck       <= sck_nxt;
      mosi      <= mosi_nxt;
      tx_ready  <= tx_ready_nxt;
      rx_data   <= rx_data_nxt;
      rx_valid  <= rx_valid_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state and next-output logic; sck/mosi only move on phase transitions.
  always_comb begin
    state_nxt     = state;
    div_cnt_nxt   = div_cnt + 8'd1;
    bit_cnt_nxt   = bit_cnt;
    tx_shift_nxt  = tx_shift;
    rx_shift_nxt  = rx_shift;
    last_byte_nxt = last_byte;
    cs_nxt        = cs;
    sck_nxt       = sck;
    mosi_nxt      = mosi;
    rx_data_nxt   = rx_data;
    rx_valid_nxt  = 1'b0;
    busy_nxt      = busy;

    case (state)
      IDLE: begin
        div_cnt_nxt = 8'd0;
        if (handshake) begin
          state_nxt     = SETUP;
          cs_nxt        = 1'b0;
          busy_nxt      = 1'b1;
          tx_shift_nxt  = tx_data;
          last_byte_nxt = tx_last;
          bit_cnt_nxt   = 3'd0;
        end
      end
      SETUP: begin
        if (div_cnt == SETUP_END) begin
          state_nxt   = LOW;
          div_cnt_nxt = 8'd0;
          sck_nxt     = 1'b0;
          mosi_nxt    = tx_shift[7];
        end
      end
      LOW: begin
        if (div_cnt == DIV_END) begin
          state_nxt    = HIGH;
          div_cnt_nxt  = 8'd0;
          sck_nxt      = 1'b1;
          rx_shift_nxt = {rx_shift[6:0], miso_sync};
        end
      end
      HIGH: begin
        if (div_cnt == DIV_END) begin
          div_cnt_nxt = 8'd0;
          if (bit_cnt != 3'd7) begin
            state_nxt    = LOW;
            bit_cnt_nxt  = bit_cnt + 3'd1;
            tx_shift_nxt = {tx_shift[6:0], 1'b0};
            sck_nxt      = 1'b0;
            mosi_nxt     = tx_shift[6];
          end else begin
            bit_cnt_nxt  = 3'd0;
            rx_data_nxt  = rx_shift;
            rx_valid_nxt = 1'b1;
            state_nxt    = last_byte ? HOLD : NEXT;
          end
        end
      end
      NEXT: begin
        // Wait indefinitely with sck high and cs low for the next burst byte.
        div_cnt_nxt = 8'd0;
        if (handshake) begin
          state_nxt     = LOW;
          tx_shift_nxt  = tx_data;
          last_byte_nxt = tx_last;
          bit_cnt_nxt   = 3'd0;
          sck_nxt       = 1'b0;
          mosi_nxt      = tx_data[7];
        end
      end
      HOLD: begin
        if (div_cnt == HOLD_END) begin
          state_nxt   = GAP;
          div_cnt_nxt = 8'd0;
          cs_nxt      = 1'b1;
          mosi_nxt    = 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == GAP_END) begin
          state_nxt   = IDLE;
          div_cnt_nxt = 8'd0;
          busy_nxt    = 1'b0;
        end
      end
      default: begin
        state_nxt   = IDLE;
        div_cnt_nxt = 8'd0;
      end
    endcase

    tx_ready_nxt = (state_nxt == IDLE) || (state_nxt == NEXT);
  end

endmodule
